// File: rtl/qam_mapper_if.sv
// qam_mapper bus: serial coded bits in,
// Gray-mapped I/Q points out.
interface qam_mapper_if #(
  parameter int WIDTH = 4
);
  logic                    in_bit;
  logic                    in_valid;
  logic [1:0]              mode;
  logic signed [WIDTH-1:0] out_i;
  logic signed [WIDTH-1:0] out_q;
  logic                    out_valid;

  modport master (
    output in_bit, in_valid, mode,
    input  out_i, out_q, out_valid
  );

  modport slave (
    input  in_bit, in_valid, mode,
    output out_i, out_q, out_valid
  );
endinterface

// File: rtl/qam_mapper.sv
// qam_mapper: groups 1/2/4/6 coded bits and
// emits one 802.11a Gray-coded I/Q point.
module qam_mapper #(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  qam_mapper_if.slave  bus
);

  logic [2:0] cnt;
  logic [5:0] sreg;
  logic [1:0] mode_q;

  logic [1:0] eff_mode;
  logic [5:0] grp;
  logic       last;
  logic signed [3:0] lvl_i;
  logic signed [3:0] lvl_q;

  function automatic logic signed [3:0] g2(
    input logic b
  );
    return b ? 4'sd1 : -4'sd1;
  endfunction

  function automatic logic signed [3:0] g4(
    input logic [1:0] b
  );
    logic signed [3:0] r;
    unique case (b)
      2'b00: r = -4'sd3;
      2'b01: r = -4'sd1;
      2'b11: r = 4'sd1;
      2'b10: r = 4'sd3;
    endcase
    return r;
  endfunction

  function automatic logic signed [3:0] g8(
    input logic [2:0] b
  );
    logic signed [3:0] r;
    unique case (b)
      3'b000: r = -4'sd7;
      3'b001: r = -4'sd5;
      3'b011: r = -4'sd3;
      3'b010: r = -4'sd1;
      3'b110: r = 4'sd1;
      3'b111: r = 4'sd3;
      3'b101: r = 4'sd5;
      3'b100: r = 4'sd7;
    endcase
    return r;
  endfunction

  // mode is taken fresh only on a group's first bit
  always_comb begin
    eff_mode = (cnt == 3'd0) ? bus.mode : mode_q;
    grp = sreg;
    for (int k = 0; k < 6; k++)
      if (cnt == 3'(k)) grp[k] = bus.in_bit;
    last = 1'b0;
    lvl_i = '0;
    lvl_q = '0;
    unique case (eff_mode)
      2'b00: begin
        last  = (cnt == 3'd0);
        lvl_i = g2(grp[0]);
      end
      2'b01: begin
        last  = (cnt == 3'd1);
        lvl_i = g2(grp[0]);
        lvl_q = g2(grp[1]);
      end
      2'b10: begin
        last  = (cnt == 3'd3);
        lvl_i = g4({grp[0], grp[1]});
        lvl_q = g4({grp[2], grp[3]});
      end
      2'b11: begin
        last  = (cnt == 3'd5);
        lvl_i = g8({grp[0], grp[1], grp[2]});
        lvl_q = g8({grp[3], grp[4], grp[5]});
      end
    endcase
  end

  // collect bits; register the point on the last one
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      sreg          <= '0;
      mode_q        <= 2'b00;
      bus.out_i     <= '0;
      bus.out_q     <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      if (bus.in_valid) begin
        if (cnt == 3'd0) mode_q <= bus.mode;
        if (last) begin
          cnt           <= '0;
          sreg          <= '0;
          bus.out_i     <= WIDTH'(lvl_i);
          bus.out_q     <= WIDTH'(lvl_q);
          bus.out_valid <= 1'b1;
        end else begin
          cnt  <= cnt + 3'd1;
          sreg <= grp;
        end
      end
    end
  end

endmodule

// File: tb/tb_qam_mapper.sv
// tb_qam_mapper: directed vectors with
// hand-computed Gray-map points.
module tb_qam_mapper;

  localparam int W = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  qam_mapper_if #(.WIDTH(W)) bus();

  qam_mapper #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(
    input string tag,
    input int    obs,
    input int    exp
  );
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d",
               tag, obs, exp);
    end
  endtask

  function automatic int oi();
    return int'($signed(bus.out_i));
  endfunction

  function automatic int oq();
    return int'($signed(bus.out_q));
  endfunction

  function automatic int ov();
    return int'(bus.out_valid);
  endfunction

  task automatic send(input logic b);
    bus.in_valid = 1'b1;
    bus.in_bit   = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pt(
    input string tag,
    input int    ei,
    input int    eq
  );
    chk({tag, "_v"}, ov(), 1);
    chk({tag, "_i"}, oi(), ei);
    chk({tag, "_q"}, oq(), eq);
  endtask

  int lv4 [4] = '{-3, -1, 3, 1};
  logic [15:0] lfsr;
  logic [3:0]  g;

  initial begin
    bus.in_bit   = 1'b0;
    bus.in_valid = 1'b0;
    bus.mode     = 2'b00;

    // 1: reset, then BPSK stream
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_v", ov(), 0);
    chk("rst_i", oi(), 0);
    chk("rst_q", oq(), 0);
    send(1'b1); pt("bp0", 1, 0);
    send(1'b0); pt("bp1", -1, 0);
    send(1'b1); pt("bp2", 1, 0);
    idle(1);
    chk("bp_idle_v", ov(), 0);

    // 2: 16-QAM 1,0,1,1
    bus.mode = 2'b10;
    send(1'b1); chk("q16a_v0", ov(), 0);
    send(1'b0); chk("q16a_v1", ov(), 0);
    send(1'b1); chk("q16a_v2", ov(), 0);
    send(1'b1); pt("q16a", 3, 1);
    idle(2);
    chk("q16a_hold_v", ov(), 0);
    chk("q16a_hold_i", oi(), 3);
    chk("q16a_hold_q", oq(), 1);

    // 3: 64-QAM with a 3-cycle gap
    bus.mode = 2'b11;
    send(1'b0);
    send(1'b1);
    idle(3);
    chk("q64_gap_v", ov(), 0);
    send(1'b1);
    send(1'b1);
    send(1'b0); chk("q64_v4", ov(), 0);
    send(1'b0); pt("q64", -3, 7);
    idle(1);
    chk("q64_once", ov(), 0);

    // 4: mode change mid-group ignored
    bus.mode = 2'b01;
    send(1'b1);
    bus.mode = 2'b10;
    send(1'b0); pt("qpsk", 1, -1);
    send(1'b0);
    send(1'b0);
    send(1'b1); chk("q16b_v2", ov(), 0);
    send(1'b0); pt("q16b", -3, 3);

    // 5: reset discards partial group
    bus.mode = 2'b10;
    send(1'b1);
    send(1'b1);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst2_v", ov(), 0);
    chk("rst2_i", oi(), 0);
    chk("rst2_q", oq(), 0);
    send(1'b0); chk("r5_v0", ov(), 0);
    send(1'b1); chk("r5_v1", ov(), 0);
    send(1'b1); chk("r5_v2", ov(), 0);
    send(1'b0); pt("r5", -1, 3);

    // 6: 192-bit 16-QAM vector, LFSR pattern
    bus.mode = 2'b10;
    lfsr = 16'hACE1;
    for (int i = 0; i < 192; i++) begin
      g[i % 4] = lfsr[0];
      send(lfsr[0]);
      lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5],
              lfsr[15:1]};
      if (i % 4 == 3)
        pt($sformatf("v%0d", i / 4),
           lv4[{g[0], g[1]}], lv4[{g[2], g[3]}]);
      else
        chk($sformatf("v%0d_gap", i), ov(), 0);
    end
    idle(1);
    // counter back at 0: next group aligns on 4 bits
    send(1'b1); chk("end_v0", ov(), 0);
    send(1'b1); chk("end_v1", ov(), 0);
    send(1'b1); chk("end_v2", ov(), 0);
    send(1'b1); pt("end", 1, 1);
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
